mult_seq_ctrl: RTL and testbench

Iterative unsigned WIDTH×WIDTH multiplier controller that time-shares a single 2×2 array multiplier cell (mult21) across all 2-bit digit pairs of its operands. It accepts one operand pair per transaction through a valid/ready handshake. It sequences the digit-pair products into a shifted accumulator and returns the 2·WIDTH-bit product through a valid/ready handshake. It sits between arithmetic clients and the shared 2×2 cell wherever area matters more than throughput.

---
 rtl/mult_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned WIDTH x WIDTH multiplier that time-shares one 2x2 array cell across all
// digit pairs. Optional macro MULT_SEQ_ZERO_SKIP_EN bypasses RUN when either operand is zero.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [IdxW-1:0]   i_q, i_d, j_q, j_d;

    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [1:0]        a_dig, b_dig;
    logic [3:0]        cell_p;
    logic [IdxW:0]     dig_sum;
    logic [PW-1:0]     pp_sh;

    // Digit select: shift by 2*index and keep the low two bits.
    assign a_sh  = a_q >> {i_q, 1'b0};
    assign b_sh  = b_q >> {j_q, 1'b0};
    assign a_dig = a_sh[1:0];
    assign b_dig = b_sh[1:0];

    // mult21: 2x2 array cell built from two partial-product half adders.
    logic t1, t2, t3, c1;
    assign t1        = a_dig[1] & b_dig[0];
    assign t2        = a_dig[0] & b_dig[1];
    assign t3        = a_dig[1] & b_dig[1];
    assign c1        = t1 & t2;
    assign cell_p[0] = a_dig[0] & b_dig[0];
    assign cell_p[1] = t1 ^ t2;
    assign cell_p[2] = t3 ^ c1;
    assign cell_p[3] = t3 & c1;

    assign dig_sum = {1'b0, i_q} + {1'b0, j_q};
    assign pp_sh   = PW'(cell_p) << {dig_sum, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StRun;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StRun: begin
                acc_d = acc_q + pp_sh;
                if (j_q == LastIdx) begin
                    j_d = '0;
                    if (i_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by rst_n so in_ready reads low while reset is held.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign product   = acc_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl (WIDTH=8): products, latency, backpressure, reset, zero.
module tb_mult_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NSQ   = (WIDTH / 2) * (WIDTH / 2);

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one transaction, holds out_ready low for 'stall' cycles once the product appears.
    task automatic run_txn(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input int stall, output int acc_cyc);
        int lat;
        int busy_cnt;
        int guard;
        int exp_lat;
        int exp_busy;
        logic [2*WIDTH-1:0] held;
        logic [2*WIDTH-1:0] exp_p;
        exp_lat  = NSQ;
        exp_busy = NSQ;
`ifdef MULT_SEQ_ZERO_SKIP_EN
        // DONE is entered on the acceptance edge itself.
        if (av == '0 || bv == '0) begin
            exp_lat  = 0;
            exp_busy = 0;
        end
`endif
        out_ready = (stall == 0);
        guard = 0;
        while (!in_ready && guard < 8) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("in_ready_before_txn", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        exp_q.push_back((2*WIDTH)'(av) * (2*WIDTH)'(bv));
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            busy_cnt += int'(busy);
            // A stray in_valid outside IDLE must be ignored.
            in_valid = (lat == 3);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        if (!out_valid) begin
            void'(exp_q.pop_front());
            out_ready = 1'b1;
            return;
        end
        exp_p = exp_q.pop_front();
        held  = product;
        check_eq("product", 32'(product), 32'(exp_p));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
            check_eq("stall_product_held", 32'(product), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("return_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'd0);
        check_eq("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_after_reset", {29'd0, in_ready, out_valid, busy}, 32'b100);

        run_txn(8'd3, 8'd3, 0, t0);
        run_txn(8'd255, 8'd255, 0, t0);
        run_txn(8'hA5, 8'h3C, 0, t0);
        run_txn(8'd1, 8'd128, 0, t0);
        run_txn(8'd0, 8'd200, 0, t0);
        run_txn(8'd77, 8'd0, 0, t0);

        // Back-to-back with out_ready tied high: one product every N^2+2 cycles.
        run_txn(8'd19, 8'd23, 0, t1);
        run_txn(8'd200, 8'd201, 0, t2);
        check_eq("throughput_period", 32'(t2 - t1), 32'(NSQ + 2));

        run_txn(8'd91, 8'd45, 10, t0);

        // Reset during RUN cycle 7: transaction dropped, no product.
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 8) begin
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b1;
        a        = 8'h5A;
        b        = 8'h77;
        exp_q.push_back(16'(8'h5A) * 16'(8'h77));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check_eq("async_reset_outputs", {29'd0, in_ready, out_valid, busy}, 32'd0);
        check_eq("async_reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) begin
                check_eq("no_product_after_reset", {30'd0, in_ready, out_valid}, 32'b10);
                break;
            end
        end
        check_eq("idle_after_midrun_reset", {29'd0, in_ready, out_valid, busy}, 32'b100);
        run_txn(8'd2, 8'd7, 0, t0);

        for (int r = 0; r < 4; r++) begin
            run_txn(WIDTH'($urandom), WIDTH'($urandom), r, t0);
        end

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
